// File: rtl/fft_stream_to_bram.sv
// Captures the low bins of each FFT magnitude frame into the back half of a
// double-buffered histogram BRAM, flipping banks and publishing the peak on each good frame.
module fft_stream_to_bram #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned IDX_W  = 12,
  parameter int unsigned KEEP_W = 10,
  parameter int unsigned OUT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic [IDX_W-1:0]  s_tuser,
  input  logic              s_tlast,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              enable,
  output logic              wr_en,
  output logic [KEEP_W:0]   wr_addr,
  output logic [OUT_W-1:0]  wr_data,
  output logic              bank,
  output logic              frame_done,
  output logic [KEEP_W-1:0] peak_bin,
  output logic [OUT_W-1:0]  peak_mag,
  output logic              err_index,
  output logic              err_tlast,
  output logic [15:0]       frame_count
);

  typedef enum logic [1:0] {StIdle, StCapture, StDrop} state_t;

  state_t            state;
  logic [IDX_W-1:0]  exp_idx;
  logic [KEEP_W-1:0] run_bin;
  logic [OUT_W-1:0]  run_mag;

  logic              beat;
  logic [OUT_W-1:0]  sat;
  logic              kept;
  logic              idx_last;
  logic              idx_match;
  logic              start;
  logic              good_beat;
  logic              bigger;
  logic [KEEP_W-1:0] nxt_bin;
  logic [OUT_W-1:0]  nxt_mag;

  // No backpressure: ready follows reset only.
  assign s_tready  = ~reset;
  assign beat      = s_tvalid & s_tready;
  assign sat       = (s_tdata[DATA_W-1:OUT_W] == '0) ? s_tdata[OUT_W-1:0] : '1;
  assign kept      = (s_tuser >> KEEP_W) == '0;
  assign idx_last  = &s_tuser;
  assign idx_match = s_tuser == exp_idx;
  assign start     = (state == StIdle) && (s_tuser == '0) && enable;
  assign good_beat = beat && (start || ((state == StCapture) && idx_match));

  // DC bin never competes; strict compare keeps the lower index on ties.
  assign bigger  = kept && (s_tuser != '0) && (sat > run_mag);
  assign nxt_bin = bigger ? s_tuser[KEEP_W-1:0] : run_bin;
  assign nxt_mag = bigger ? sat : run_mag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= StIdle;
      exp_idx     <= '0;
      run_bin     <= '0;
      run_mag     <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      bank        <= 1'b0;
      frame_done  <= 1'b0;
      peak_bin    <= '0;
      peak_mag    <= '0;
      err_index   <= 1'b0;
      err_tlast   <= 1'b0;
      frame_count <= '0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      err_index  <= 1'b0;
      err_tlast  <= 1'b0;

      if (good_beat && kept) begin
        wr_en   <= 1'b1;
        wr_addr <= {~bank, s_tuser[KEEP_W-1:0]};
        wr_data <= sat;
      end

      if (beat) begin
        case (state)
          StIdle: begin
            if (start) begin
              exp_idx <= IDX_W'(1);
              run_bin <= '0;
              run_mag <= '0;
              state   <= StCapture;
            end
          end
          StCapture: begin
            if (!idx_match) begin
              err_index <= 1'b1;
              state     <= s_tlast ? StIdle : StDrop;
            end else if (s_tlast && !idx_last) begin
              err_tlast <= 1'b1;
              state     <= StIdle;
            end else if (idx_last && !s_tlast) begin
              err_tlast <= 1'b1;
              state     <= StDrop;
            end else begin
              run_bin <= nxt_bin;
              run_mag <= nxt_mag;
              if (idx_last) begin
                frame_done  <= 1'b1;
                bank        <= ~bank;
                peak_bin    <= nxt_bin;
                peak_mag    <= nxt_mag;
                frame_count <= frame_count + 16'd1;
                state       <= StIdle;
              end else begin
                exp_idx <= exp_idx + 1'b1;
              end
            end
          end
          StDrop: begin
            if (s_tlast) state <= StIdle;
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fft_stream_to_bram.sv
// Directed bench for fft_stream_to_bram: framing, saturation, peak tracking, bank swap, reset.
module tb_fft_stream_to_bram;

  logic        clk;
  logic        reset;
  logic [23:0] s_tdata;
  logic [11:0] s_tuser;
  logic        s_tlast;
  logic        s_tvalid;
  logic        s_tready;
  logic        enable;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [15:0] wr_data;
  logic        bank;
  logic        frame_done;
  logic [9:0]  peak_bin;
  logic [15:0] peak_mag;
  logic        err_index;
  logic        err_tlast;
  logic [15:0] frame_count;

  int checks = 0;
  int errors = 0;

  int          wcnt [2048];
  logic [15:0] wdat [2048];
  int n_wr = 0, fd_cnt = 0, ei_cnt = 0, et_cnt = 0, both_cnt = 0;
  logic probe_ei, probe_et, probe_wr;

  fft_stream_to_bram #(
    .DATA_W(24), .IDX_W(12), .KEEP_W(10), .OUT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tlast(s_tlast),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .enable(enable), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .bank(bank), .frame_done(frame_done),
    .peak_bin(peak_bin), .peak_mag(peak_mag), .err_index(err_index), .err_tlast(err_tlast),
    .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log of what the DUT presented, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wcnt[int'(wr_addr)]++;
      wdat[int'(wr_addr)] = wr_data;
      n_wr++;
    end
    if (frame_done === 1'b1) fd_cnt++;
    if (err_index === 1'b1) ei_cnt++;
    if (err_tlast === 1'b1) et_cnt++;
    if (err_index === 1'b1 && err_tlast === 1'b1) both_cnt++;
  end

  function automatic logic [23:0] pat_data(input int pat, input int idx);
    if (pat == 0) return 24'(idx);
    case (idx)
      0:       return 24'hFFFFFF;
      5:       return 24'h010000;
      7:       return 24'h00FFFF;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic clear_log();
    for (int i = 0; i < 2048; i++) wcnt[i] = 0;
    n_wr = 0;
  endtask

  task automatic beat(input logic [23:0] d, input int idx, input bit last);
    @(negedge clk);
    s_tdata  = d;
    s_tuser  = idx[11:0];
    s_tlast  = last;
    s_tvalid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input int pat, input int gap, input int start_idx, input int skip_idx,
                       input int last_idx, input int end_idx, input int noen_idx,
                       input int probe_idx);
    for (int idx = start_idx; idx <= end_idx; idx++) begin
      if (idx == skip_idx) continue;
      while (int'($urandom_range(99)) < gap) begin
        @(negedge clk);
        s_tvalid = 1'b0;
      end
      if (idx == noen_idx) enable = 1'b0;
      beat(pat_data(pat, idx), idx, idx == last_idx);
      if (idx == probe_idx) begin
        probe_ei = err_index;
        probe_et = err_tlast;
        probe_wr = wr_en;
      end
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    #1;
  endtask

  function automatic int bad_ramp(input int base);
    int bad = 0;
    for (int i = 0; i < 1024; i++)
      if (wcnt[base + i] != 1 || wdat[base + i] !== 16'(i)) bad++;
    return bad;
  endfunction

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1;
    s_tdata = '0; s_tuser = '0; s_tlast = 1'b0; s_tvalid = 1'b0;
    #2;
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL rst_tready got %b exp 0", s_tready); end
    checks++; if ({wr_en, wr_addr, wr_data, bank, frame_done, peak_bin, peak_mag, err_index,
                   err_tlast, frame_count} !== '0) begin
      errors++; $display("FAIL rst_outputs got nonzero exp all 0");
    end
    @(negedge clk); reset = 1'b0; #1;
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL tready got %b exp 1", s_tready); end
  endtask

  task automatic test_clean_frame();
    clear_log();
    frame(0, 0, 0, -1, 4095, 4095, -1, 0);
    checks++; if (probe_wr !== 1'b1) begin errors++; $display("FAIL t1_wr_lat got %b exp 1", probe_wr); end
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL t1_done got %b exp 1", frame_done); end
    checks++; if (bank !== 1'b1) begin errors++; $display("FAIL t1_bank got %b exp 1", bank); end
    checks++; if (peak_bin !== 10'd1023) begin errors++; $display("FAIL t1_pbin got %0d exp 1023", peak_bin); end
    checks++; if (peak_mag !== 16'd1023) begin errors++; $display("FAIL t1_pmag got %0d exp 1023", peak_mag); end
    checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL t1_count got %0d exp 1", frame_count); end
    checks++; if (n_wr != 1024) begin errors++; $display("FAIL t1_nwr got %0d exp 1024", n_wr); end
    checks++; if (bad_ramp(1024) != 0) begin errors++; $display("FAIL t1_data got %0d bad exp 0", bad_ramp(1024)); end
  endtask

  task automatic test_saturate();
    clear_log();
    frame(1, 0, 0, -1, 4095, 4095, -1, -1);
    checks++; if (wdat[0] !== 16'hFFFF) begin errors++; $display("FAIL t2_bin0 got %h exp ffff", wdat[0]); end
    checks++; if (wdat[5] !== 16'hFFFF) begin errors++; $display("FAIL t2_bin5 got %h exp ffff", wdat[5]); end
    checks++; if (wdat[7] !== 16'hFFFF) begin errors++; $display("FAIL t2_bin7 got %h exp ffff", wdat[7]); end
    checks++; if (wdat[6] !== 16'h0000) begin errors++; $display("FAIL t2_bin6 got %h exp 0000", wdat[6]); end
    checks++; if (n_wr != 1024) begin errors++; $display("FAIL t2_nwr got %0d exp 1024", n_wr); end
    checks++; if (peak_bin !== 10'd5) begin errors++; $display("FAIL t2_pbin got %0d exp 5", peak_bin); end
    checks++; if (peak_mag !== 16'hFFFF) begin errors++; $display("FAIL t2_pmag got %h exp ffff", peak_mag); end
    checks++; if (bank !== 1'b0) begin errors++; $display("FAIL t2_bank got %b exp 0", bank); end
    checks++; if (frame_count !== 16'd2) begin errors++; $display("FAIL t2_count got %0d exp 2", frame_count); end
  endtask

  task automatic test_index_jump();
    int fd0;
    clear_log();
    fd0 = fd_cnt;
    frame(0, 0, 0, 101, 4095, 4095, -1, 102);
    checks++; if (probe_ei !== 1'b1) begin errors++; $display("FAIL t3_err_index got %b exp 1", probe_ei); end
    checks++; if (probe_et !== 1'b0) begin errors++; $display("FAIL t3_err_tlast got %b exp 0", probe_et); end
    checks++; if (probe_wr !== 1'b0) begin errors++; $display("FAIL t3_wr102 got %b exp 0", probe_wr); end
    checks++; if (n_wr != 101) begin errors++; $display("FAIL t3_nwr got %0d exp 101", n_wr); end
    checks++; if (fd_cnt != fd0) begin errors++; $display("FAIL t3_done got %0d exp %0d", fd_cnt, fd0); end
    checks++; if (bank !== 1'b0) begin errors++; $display("FAIL t3_bank got %b exp 0", bank); end
    checks++; if (peak_bin !== 10'd5) begin errors++; $display("FAIL t3_pbin got %0d exp 5", peak_bin); end
    frame(0, 0, 0, -1, 4095, 4095, -1, -1);
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL t3_done2 got %b exp 1", frame_done); end
    checks++; if (bank !== 1'b1) begin errors++; $display("FAIL t3_bank2 got %b exp 1", bank); end
    checks++; if (frame_count !== 16'd3) begin errors++; $display("FAIL t3_count got %0d exp 3", frame_count); end
  endtask

  task automatic test_tlast();
    int fd0;
    frame(0, 0, 0, -1, 2000, 2000, -1, 2000);
    checks++; if (probe_et !== 1'b1) begin errors++; $display("FAIL t4_early_tlast got %b exp 1", probe_et); end
    checks++; if (probe_ei !== 1'b0) begin errors++; $display("FAIL t4_early_idx got %b exp 0", probe_ei); end
    checks++; if (frame_count !== 16'd3) begin errors++; $display("FAIL t4_count got %0d exp 3", frame_count); end
    frame(0, 0, 0, -1, -1, 4095, -1, 4095);
    checks++; if (probe_et !== 1'b1) begin errors++; $display("FAIL t4_miss_tlast got %b exp 1", probe_et); end
    checks++; if (probe_ei !== 1'b0) begin errors++; $display("FAIL t4_miss_idx got %b exp 0", probe_ei); end
    clear_log();
    fd0 = fd_cnt;
    frame(0, 0, 0, -1, 4095, 4095, -1, -1);
    checks++; if (n_wr != 0) begin errors++; $display("FAIL t4_drop_nwr got %0d exp 0", n_wr); end
    checks++; if (fd_cnt != fd0) begin errors++; $display("FAIL t4_drop_done got %0d exp %0d", fd_cnt, fd0); end
    frame(0, 0, 0, -1, 4095, 4095, -1, -1);
    checks++; if (frame_count !== 16'd4) begin errors++; $display("FAIL t4_count2 got %0d exp 4", frame_count); end
    checks++; if (bank !== 1'b0) begin errors++; $display("FAIL t4_bank got %b exp 0", bank); end
  endtask

  task automatic test_gaps_enable();
    int fd0;
    clear_log();
    frame(0, 30, 0, -1, 4095, 4095, 2000, -1);
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL t5_done got %b exp 1", frame_done); end
    checks++; if (bank !== 1'b1) begin errors++; $display("FAIL t5_bank got %b exp 1", bank); end
    checks++; if (peak_bin !== 10'd1023) begin errors++; $display("FAIL t5_pbin got %0d exp 1023", peak_bin); end
    checks++; if (peak_mag !== 16'd1023) begin errors++; $display("FAIL t5_pmag got %0d exp 1023", peak_mag); end
    checks++; if (frame_count !== 16'd5) begin errors++; $display("FAIL t5_count got %0d exp 5", frame_count); end
    checks++; if (n_wr != 1024) begin errors++; $display("FAIL t5_nwr got %0d exp 1024", n_wr); end
    checks++; if (bad_ramp(1024) != 0) begin errors++; $display("FAIL t5_data got %0d bad exp 0", bad_ramp(1024)); end
    clear_log();
    fd0 = fd_cnt;
    frame(0, 30, 0, -1, 4095, 4095, -1, -1);
    checks++; if (n_wr != 0) begin errors++; $display("FAIL t5_off_nwr got %0d exp 0", n_wr); end
    checks++; if (fd_cnt != fd0) begin errors++; $display("FAIL t5_off_done got %0d exp %0d", fd_cnt, fd0); end
    checks++; if (frame_count !== 16'd5) begin errors++; $display("FAIL t5_off_count got %0d exp 5", frame_count); end
    enable = 1'b1;
  endtask

  task automatic test_async_reset();
    int fd0;
    frame(0, 0, 0, -1, -1, 500, -1, 500);
    checks++; if (probe_wr !== 1'b1) begin errors++; $display("FAIL t6_pre_wr got %b exp 1", probe_wr); end
    #1 reset = 1'b1;
    #1;
    checks++; if (bank !== 1'b0) begin errors++; $display("FAIL t6_bank got %b exp 0", bank); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL t6_count got %0d exp 0", frame_count); end
    checks++; if ({s_tready, wr_en, wr_addr, wr_data, frame_done, peak_bin, peak_mag, err_index,
                   err_tlast} !== '0) begin
      errors++; $display("FAIL t6_outputs got nonzero exp all 0");
    end
    @(negedge clk); reset = 1'b0;
    clear_log();
    fd0 = fd_cnt;
    frame(0, 0, 501, -1, 4095, 4095, -1, -1);
    checks++; if (n_wr != 0) begin errors++; $display("FAIL t6_discard_nwr got %0d exp 0", n_wr); end
    checks++; if (fd_cnt != fd0) begin errors++; $display("FAIL t6_discard_done got %0d exp %0d", fd_cnt, fd0); end
    clear_log();
    frame(0, 0, 0, -1, 4095, 4095, -1, -1);
    checks++; if (bank !== 1'b1) begin errors++; $display("FAIL t6_bank2 got %b exp 1", bank); end
    checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL t6_count2 got %0d exp 1", frame_count); end
    checks++; if (bad_ramp(1024) != 0) begin errors++; $display("FAIL t6_data got %0d bad exp 0", bad_ramp(1024)); end
  endtask

  task automatic test_err_pulses();
    checks++; if (both_cnt != 0) begin errors++; $display("FAIL err_both got %0d exp 0", both_cnt); end
    checks++; if (ei_cnt != 1) begin errors++; $display("FAIL err_index_total got %0d exp 1", ei_cnt); end
    checks++; if (et_cnt != 2) begin errors++; $display("FAIL err_tlast_total got %0d exp 2", et_cnt); end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_saturate();
    test_index_jump();
    test_tlast();
    test_gaps_enable();
    test_async_reset();
    test_err_pulses();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_stream_to_bram.md
Name: fft_stream_to_bram

Overview:
- AXI-stream slave that takes the 4096-point FFT magnitude stream (tdata, tuser index, tlast) from fft_mag.
- Checks framing and keeps bins 0..2^KEEP_W-1, saturating each to 16 bits.
- Writes kept bins into the back half of a double-buffered histogram BRAM, then swaps banks on each complete, error-free frame.
- Tracks the per-frame peak bin. Sits in the clk_104mhz domain between fft_mag and the histogram BRAM write port.

Parameters:
- DATA_W, 24, width of s_tdata
- IDX_W, 12, width of s_tuser; frame length is 2^IDX_W beats
- KEEP_W, 10, log2 of the number of bins kept (bins 0..2^KEEP_W-1)
- OUT_W, 16, width of stored magnitude

Ports:
- clk  in  1  system clock (clk_104mhz)
- reset  in  1  asynchronous, active-high reset
- s_tdata  in  DATA_W  FFT magnitude
- s_tuser  in  IDX_W  bin index of current beat
- s_tlast  in  1  last beat of frame
- s_tvalid  in  1  beat valid
- s_tready  out  1  slave ready
- enable  in  1  allow capture of new frames
- wr_en  out  1  BRAM write strobe
- wr_addr  out  KEEP_W+1  {back bank, bin}
- wr_data  out  OUT_W  saturated magnitude
- bank  out  1  bank that is complete and safe to read
- frame_done  out  1  one-cycle pulse on good frame
- peak_bin  out  KEEP_W  index of max bin of last good frame
- peak_mag  out  OUT_W  magnitude of that bin
- err_index  out  1  one-cycle pulse: index discontinuity
- err_tlast  out  1  one-cycle pulse: tlast misplaced
- frame_count  out  16  good frames since reset, wraps at 16'hFFFF

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high, named reset. Asserting reset immediately forces every output and register to 0, state IDLE, bank 0, with no clock edge required.
- Handshake: s_tready = 1 whenever reset is low, with no backpressure. A beat is accepted when s_tvalid & s_tready. Bubbles (s_tvalid low) are allowed anywhere and have no effect.
- Expected index: exp_idx is an IDX_W-bit counter.
- State IDLE:
  - Accepted beat with s_tuser==0 and enable==1: process it as bin 0, set exp_idx=1, clear running peak, go to CAPTURE.
  - Any other beat: discarded.
  - enable is sampled only in IDLE. Deasserting it mid-frame does not abort the frame.
- State CAPTURE, for each accepted beat:
  - s_tuser != exp_idx: pulse err_index, no write, go to DROP. If s_tlast is also set on that beat, go to IDLE instead.
  - s_tuser == exp_idx, s_tlast==1, s_tuser != all-ones: pulse err_tlast, go to IDLE.
  - s_tuser == all-ones, s_tlast==0: pulse err_tlast, go to DROP.
  - s_tuser == all-ones, s_tlast==1: good frame. Next cycle: frame_done=1, bank toggles, peak_bin/peak_mag load the running peak, frame_count increments. Go to IDLE.
  - Otherwise: normal beat, exp_idx increments.
- State DROP: discard beats until an accepted beat with s_tlast, then go to IDLE.
- Writes:
  - Condition: a matching beat in IDLE-start or CAPTURE with s_tuser < 2^KEEP_W.
  - Timing: registered, so wr_en is high exactly one cycle after the beat.
  - wr_addr = {~bank, s_tuser[KEEP_W-1:0]}.
  - wr_data = s_tdata[OUT_W-1:0] if s_tdata[DATA_W-1:OUT_W]==0, else all-ones (saturate).
- Running peak:
  - Covers bins 1..2^KEEP_W-1 only; DC bin 0 is excluded.
  - Compares on the saturated value.
  - Updates only on strictly greater, so ties keep the lower index.
  - If all bins are 0: peak_bin=0, peak_mag=0.
- Failed frames: bank, peak, and frame_count are unchanged. The back bank may be partially overwritten; readers only use the bank given by `bank`.
- Error pulses: err_index and err_tlast appear one cycle after the offending beat and are never both high.

Test Plan:
1. Reset, enable=1, clean frame with tdata=index, tvalid continuous -> 1024 writes with wr_addr={1,i}, wr_data=i; frame_done one cycle after beat 4095; bank=1; peak_bin=1023, peak_mag=1023; frame_count=1.
2. Frame with bin0=24'hFFFFFF, bin5=24'h010000, bin7=24'h00FFFF, all others 0 -> wr_data for bins 0/5/7 = 16'hFFFF; peak_bin=5, peak_mag=16'hFFFF.
3. Frame whose tuser jumps 100->102 -> no write for 102; err_index pulse one cycle after that beat; no frame_done; bank unchanged; following clean frame completes and bank toggles.
4. tlast on tuser=2000 -> err_tlast pulse, state IDLE, frame_count unchanged; then tlast missing at tuser=4095 on the next frame -> err_tlast, DROP until tlast, then a good frame is accepted.
5. Clean frames with random 30% tvalid gaps, plus enable dropped mid-frame -> identical writes and peak as test 1; the in-flight frame completes; the next frame is ignored while enable=0.
6. Assert reset asynchronously at beat 500 -> all outputs 0 before the next edge, bank=0. After release, beats until the next tuser==0 are discarded and produce no writes.
